// File: rtl/elevator_pkg.sv
// Shared defaults and scheduler state encoding for the elevator request path.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 4;
  localparam int unsigned FLOOR_W    = 2;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    OFFER,
    WAIT_ARRIVE
  } sched_state_e;

endpackage

// File: rtl/nearest_floor_sel.sv
// Finds the nearest pending floor strictly above and strictly below the current floor.
module nearest_floor_sel #(
  parameter int unsigned NUM_FLOORS = 4,
  parameter int unsigned FLOOR_W    = 2
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic                  found_above,
  output logic [FLOOR_W-1:0]    idx_above,
  output logic                  found_below,
  output logic [FLOOR_W-1:0]    idx_below
);

  // Scan away from the car so the last hit is the closest one.
  always_comb begin
    found_above = 1'b0;
    idx_above   = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (FLOOR_W'(i) > cur_floor)) begin
        found_above = 1'b1;
        idx_above   = FLOOR_W'(i);
      end
    end
  end

  always_comb begin
    found_below = 1'b0;
    idx_below   = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (FLOOR_W'(i) < cur_floor)) begin
        found_below = 1'b1;
        idx_below   = FLOOR_W'(i);
      end
    end
  end

endmodule

// File: rtl/floor_request_scheduler.sv
// SCAN request scheduler: latches floor requests, picks the next target and offers it
// to the motion FSM, with a watchdog on arrival.
module floor_request_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS  = elevator_pkg::NUM_FLOORS,
  parameter int unsigned FLOOR_W     = elevator_pkg::FLOOR_W,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] cab_req,
  input  logic [NUM_FLOORS-1:0] hall_req,
  input  logic [FLOOR_W-1:0]    actual_stage,
  input  logic                  arrive,
  input  logic                  target_ready,
  output logic                  target_valid,
  output logic [FLOOR_W-1:0]    target_stage,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  idle,
  output logic                  fault
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  sched_state_e          state;
  logic [CNT_W-1:0]      wd_cnt;
  logic [NUM_FLOORS-1:0] pending_d;

  logic                  found_above, found_below;
  logic [FLOOR_W-1:0]    idx_above, idx_below;
  logic                  sel_found, sel_flip;
  logic [FLOOR_W-1:0]    sel_idx;

  // Arrival clears a floor even if its button is still held in the same cycle.
  always_comb begin
    pending_d = pending;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (arrive && (actual_stage == FLOOR_W'(i))) begin
        pending_d[i] = 1'b0;
      end else if (cab_req[i] || hall_req[i]) begin
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_d;
    end
  end

  nearest_floor_sel #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_sel (
    .pending     (pending),
    .cur_floor   (actual_stage),
    .found_above (found_above),
    .idx_above   (idx_above),
    .found_below (found_below),
    .idx_below   (idx_below)
  );

  // Keep sweeping in the current direction; reverse only when nothing lies ahead.
  always_comb begin
    sel_found = 1'b1;
    sel_flip  = 1'b0;
    sel_idx   = actual_stage;
    if (dir_up && found_above) begin
      sel_idx = idx_above;
    end else if (!dir_up && found_below) begin
      sel_idx = idx_below;
    end else if (found_above || found_below) begin
      sel_flip = 1'b1;
      sel_idx  = found_above ? idx_above : idx_below;
    end else begin
      sel_found = pending[actual_stage];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      target_stage <= '0;
      target_valid <= 1'b0;
      dir_up       <= 1'b1;
      idle         <= 1'b1;
      fault        <= 1'b0;
      wd_cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pending != '0) begin
            state <= SELECT;
            idle  <= 1'b0;
          end
        end
        SELECT: begin
          if (sel_found) begin
            target_stage <= sel_idx;
            target_valid <= 1'b1;
            if (sel_flip) dir_up <= ~dir_up;
            state <= OFFER;
          end else begin
            // Requests can vanish via off-target arrivals; fall back to idle.
            state <= IDLE;
            idle  <= 1'b1;
          end
        end
        OFFER: begin
          if (target_ready) begin
            target_valid <= 1'b0;
            wd_cnt       <= '0;
            state        <= WAIT_ARRIVE;
          end
        end
        WAIT_ARRIVE: begin
          if (arrive && (actual_stage == target_stage)) begin
            if (pending_d != '0) begin
              state <= SELECT;
            end else begin
              state <= IDLE;
              idle  <= 1'b1;
            end
          end else if (wd_cnt == CNT_LAST) begin
            fault <= 1'b1;
            state <= SELECT;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          idle  <= 1'b1;
        end
      endcase
    end
  end

endmodule
